// File: rtl/mul_div_sequencer.sv
// Single-issue MUL/DIV/MOD controller between execute and the shared multiplier/divider units.
// Optional build macro: MUL_DIV_SEQ_DIV_ZERO_BYPASS_EN (zero-denominator divides answered without dispatch).
module mul_div_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_enable,
  input  logic [2:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_illegal,
  output logic                  mul_enable,
  output logic [DATA_WIDTH-1:0] mul_x,
  output logic [DATA_WIDTH-1:0] mul_y,
  input  logic                  mul_can_accept_cmd,
  input  logic                  mul_data_ready,
  input  logic [DATA_WIDTH-1:0] mul_prod,
  output logic                  div_enable,
  output logic                  div_unsgn_or_sgn,
  output logic [DATA_WIDTH-1:0] div_num,
  output logic [DATA_WIDTH-1:0] div_denom,
  input  logic                  div_can_accept_cmd,
  input  logic                  div_data_ready,
  input  logic [DATA_WIDTH-1:0] div_quot,
  input  logic [DATA_WIDTH-1:0] div_rem
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RESULT
  } state_t;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_SDIV = 3'd2;
  localparam logic [2:0] OP_UMOD = 3'd3;
  localparam logic [2:0] OP_SMOD = 3'd4;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] opA_q, opA_d;
  logic [DATA_WIDTH-1:0] opB_q, opB_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [TAG_WIDTH-1:0]  resTag_q, resTag_d;
  logic                  illegal_q, illegal_d;
  logic                  valid_q, valid_d;

  logic                  opLegal;
  logic                  opIsMul;
  logic                  opIsSigned;
  logic                  opIsMod;
  logic                  zeroBypass;
  logic                  targetCanAccept;
  logic                  targetReady;
  logic                  issueFire;
  logic [DATA_WIDTH-1:0] unitResult;

  assign opLegal    = (op_q <= OP_SMOD);
  assign opIsMul    = (op_q == OP_MUL);
  assign opIsSigned = (op_q == OP_SDIV) || (op_q == OP_SMOD);
  assign opIsMod    = (op_q == OP_UMOD) || (op_q == OP_SMOD);

`ifdef MUL_DIV_SEQ_DIV_ZERO_BYPASS_EN
  assign zeroBypass = opLegal && !opIsMul && (opB_q == '0);
`else
  assign zeroBypass = 1'b0;
`endif

  assign targetCanAccept = opIsMul ? mul_can_accept_cmd : div_can_accept_cmd;
  assign targetReady     = opIsMul ? mul_data_ready     : div_data_ready;
  assign unitResult      = opIsMul ? mul_prod : (opIsMod ? div_rem : div_quot);

  // A unit is only strobed while it reports it can take a command, so a busy unit stalls ISSUE.
  assign issueFire  = (state_q == ISSUE) && opLegal && !zeroBypass && targetCanAccept;
  assign mul_enable = issueFire && opIsMul;
  assign div_enable = issueFire && !opIsMul;

  assign div_unsgn_or_sgn = opIsSigned;
  assign mul_x            = opA_q;
  assign mul_y            = opB_q;
  assign div_num          = opA_q;
  assign div_denom        = opB_q;

  assign out_ready   = (state_q == IDLE);
  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_tag     = resTag_q;
  assign out_illegal = illegal_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    tag_d     = tag_q;
    result_d  = result_q;
    resTag_d  = resTag_q;
    illegal_d = illegal_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_enable) begin
          op_d    = in_op;
          opA_d   = in_a;
          opB_d   = in_b;
          tag_d   = in_tag;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!opLegal) begin
          result_d  = '0;
          resTag_d  = tag_q;
          illegal_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = RESULT;
        end else if (zeroBypass) begin
          result_d  = opIsMod ? opA_q : '1;
          resTag_d  = tag_q;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = RESULT;
        end else if (targetCanAccept) begin
          state_d = WAIT_DONE;
        end
      end
      // The unit drops can_accept_cmd after the strobe, so a stale data_ready is never taken here.
      WAIT_DONE: begin
        if (targetCanAccept && targetReady) begin
          result_d  = unitResult;
          resTag_d  = tag_q;
          illegal_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = RESULT;
        end
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      tag_q     <= '0;
      result_q  <= '0;
      resTag_q  <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      resTag_q  <= resTag_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer with small behavioural multiplier and divider models.
module tb_mul_div_sequencer;

  localparam int DIV_LAT = 30;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_enable;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_illegal;
  logic        mul_enable;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic        mul_can_accept_cmd = 1'b1;
  logic        mul_data_ready = 1'b0;
  logic [31:0] mul_prod = 32'd0;
  logic        div_enable;
  logic        div_unsgn_or_sgn;
  logic [31:0] div_num;
  logic [31:0] div_denom;
  logic        div_can_accept_cmd = 1'b1;
  logic        div_data_ready = 1'b0;
  logic [31:0] div_quot = 32'd0;
  logic [31:0] div_rem = 32'd0;

  int checkCount = 0;
  int errorCount = 0;

  int mulEnCount = 0;
  int divEnCount = 0;
  int bothEnCount = 0;
  int validCount = 0;
  int acceptCount = 0;
  logic sgnAtDivEn = 1'b0;

  logic [31:0] divNumL = 32'd0;
  logic [31:0] divDenL = 32'd0;
  logic        divSgnL = 1'b0;
  int          divCount = 0;

  always #5 clk = ~clk;

  mul_div_sequencer dut (
    .clk(clk), .rst(rst), .in_enable(in_enable), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_ready(out_ready),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag),
    .out_illegal(out_illegal), .mul_enable(mul_enable), .mul_x(mul_x),
    .mul_y(mul_y), .mul_can_accept_cmd(mul_can_accept_cmd),
    .mul_data_ready(mul_data_ready), .mul_prod(mul_prod),
    .div_enable(div_enable), .div_unsgn_or_sgn(div_unsgn_or_sgn),
    .div_num(div_num), .div_denom(div_denom),
    .div_can_accept_cmd(div_can_accept_cmd), .div_data_ready(div_data_ready),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  // Multiplier model: busy for one cycle after the strobe, then product ready; no reset.
  always @(posedge clk) begin
    if (mul_enable && mul_can_accept_cmd) begin
      mul_can_accept_cmd <= 1'b0;
      mul_data_ready     <= 1'b0;
      mul_prod           <= mul_x * mul_y;
    end else if (!mul_can_accept_cmd) begin
      mul_can_accept_cmd <= 1'b1;
      mul_data_ready     <= 1'b1;
    end
  end

  function automatic logic [63:0] divide(input logic [31:0] n, input logic [31:0] d, input logic sgn);
    logic signed [31:0] sn;
    logic signed [31:0] sd;
    sn = n;
    sd = d;
    if (d == 32'd0) return {32'hFFFF_FFFF, n};
    if (sgn) return {32'(sn / sd), 32'(sn % sd)};
    return {n / d, n % d};
  endfunction

  // Divider model: fixed multi-cycle latency, no reset.
  always @(posedge clk) begin
    if (div_enable && div_can_accept_cmd) begin
      div_can_accept_cmd <= 1'b0;
      div_data_ready     <= 1'b0;
      divNumL            <= div_num;
      divDenL            <= div_denom;
      divSgnL            <= div_unsgn_or_sgn;
      divCount           <= DIV_LAT;
    end else if (divCount > 1) begin
      divCount <= divCount - 1;
    end else if (divCount == 1) begin
      divCount           <= 0;
      {div_quot, div_rem} <= divide(divNumL, divDenL, divSgnL);
      div_can_accept_cmd <= 1'b1;
      div_data_ready     <= 1'b1;
    end
  end

  // Activity monitor sampled away from the active edge.
  always @(negedge clk) begin
    if (mul_enable) mulEnCount <= mulEnCount + 1;
    if (div_enable) begin
      divEnCount <= divEnCount + 1;
      sgnAtDivEn <= div_unsgn_or_sgn;
    end
    if (mul_enable && div_enable) bothEnCount <= bothEnCount + 1;
    if (out_valid) validCount <= validCount + 1;
    if (in_enable && out_ready && !rst) acceptCount <= acceptCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents a command, waits for its acceptance, then counts cycles until out_valid.
  // Returns at the negedge where out_valid is seen (latency 1 = the ISSUE cycle).
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] tag, input bit hold, output int latency,
                               output bit readyLeak);
    int guard;
    @(negedge clk);
    in_enable = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    guard     = 0;
    readyLeak = 1'b0;
    while (!out_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!out_ready) checkOutput("acceptTimeout", 32'd0, 32'd1);
    @(negedge clk);
    if (!hold) in_enable = 1'b0;
    latency = 1;
    while (!out_valid && latency < 60) begin
      if (out_ready) readyLeak = 1'b1;
      @(negedge clk);
      latency++;
    end
    if (out_ready) readyLeak = 1'b1;
    in_enable = 1'b0;
    if (!out_valid) checkOutput("validTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    bit leak;
    int mulBase, divBase, validBase, acceptBase;

    rst = 1'b1;
    in_enable = 1'b0;
    in_op = 3'd0;
    in_a = 32'd0;
    in_b = 32'd0;
    in_tag = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("rstReady", {31'd0, out_ready}, 32'd1);
    checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstIllegal", {31'd0, out_illegal}, 32'd0);
    checkOutput("rstResult", out_result, 32'd0);
    checkOutput("rstTag", {28'd0, out_tag}, 32'd0);
    checkOutput("rstMulEn", {31'd0, mul_enable}, 32'd0);
    checkOutput("rstDivEn", {31'd0, div_enable}, 32'd0);
    checkOutput("rstSgn", {31'd0, div_unsgn_or_sgn}, 32'd0);
    checkOutput("rstMulX", mul_x, 32'd0);
    checkOutput("rstDivDenom", div_denom, 32'd0);
    rst = 1'b0;

    // MUL with idle multiplier
    applyStimulus(3'd0, 32'h0001_0003, 32'h0002_0005, 4'd7, 1'b0, lat, leak);
    checkOutput("mulLatency", lat, 32'd4);
    checkOutput("mulResult", out_result, 32'h000B_000F);
    checkOutput("mulTag", {28'd0, out_tag}, 32'd7);
    checkOutput("mulIllegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    checkOutput("mulPulse", {31'd0, out_valid}, 32'd0);
    checkOutput("mulHold", out_result, 32'h000B_000F);

    // Signed divide then signed modulo
    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 4'd3, 1'b0, lat, leak);
    checkOutput("sdivLatencyOk", {31'd0, lat <= 40}, 32'd1);
    checkOutput("sdivResult", out_result, 32'hFFFF_FFFD);
    checkOutput("sdivTag", {28'd0, out_tag}, 32'd3);
    checkOutput("sdivSgn", {31'd0, sgnAtDivEn}, 32'd1);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd4, 1'b0, lat, leak);
    checkOutput("smodLatencyOk", {31'd0, lat <= 40}, 32'd1);
    checkOutput("smodResult", out_result, 32'hFFFF_FFFF);
    checkOutput("smodTag", {28'd0, out_tag}, 32'd4);

    // UDIV with in_enable held high throughout
    acceptBase = acceptCount;
    applyStimulus(3'd1, 32'd100, 32'd7, 4'd12, 1'b1, lat, leak);
    checkOutput("udivResult", out_result, 32'd14);
    checkOutput("udivSgn", {31'd0, sgnAtDivEn}, 32'd0);
    checkOutput("udivReadyLow", {31'd0, leak}, 32'd0);
    @(negedge clk);
    checkOutput("udivAccepts", acceptCount - acceptBase, 32'd1);
    checkOutput("udivReadyBack", {31'd0, out_ready}, 32'd1);

    // Illegal op
    mulBase = mulEnCount;
    divBase = divEnCount;
    applyStimulus(3'd6, 32'd5, 32'd6, 4'd9, 1'b0, lat, leak);
    checkOutput("illLatency", lat, 32'd2);
    checkOutput("illResult", out_result, 32'd0);
    checkOutput("illFlag", {31'd0, out_illegal}, 32'd1);
    checkOutput("illTag", {28'd0, out_tag}, 32'd9);
    checkOutput("illNoEnable", (mulEnCount - mulBase) + (divEnCount - divBase), 32'd0);

    // Reset in the middle of a UDIV, with a simultaneous command strobe
    @(negedge clk);
    in_enable = 1'b1;
    in_op = 3'd1;
    in_a = 32'd50;
    in_b = 32'd5;
    in_tag = 4'd2;
    @(negedge clk);
    in_enable = 1'b0;
    repeat (5) @(negedge clk);
    validBase = validCount;
    rst = 1'b1;
    in_enable = 1'b1;
    in_op = 3'd0;
    in_a = 32'd3;
    in_b = 32'd5;
    in_tag = 4'd5;
    @(negedge clk);
    rst = 1'b0;
    in_enable = 1'b0;
    checkOutput("rstMidReady", {31'd0, out_ready}, 32'd1);
    checkOutput("rstMidValid", {31'd0, out_valid}, 32'd0);
    applyStimulus(3'd0, 32'd3, 32'd5, 4'd5, 1'b0, lat, leak);
    checkOutput("rstMulLatency", lat, 32'd4);
    checkOutput("rstMulResult", out_result, 32'd15);
    checkOutput("rstMulTag", {28'd0, out_tag}, 32'd5);
    repeat (45) @(negedge clk);
    checkOutput("noStaleValid", validCount - validBase, 32'd1);

    // Zero denominator
    divBase = divEnCount;
    applyStimulus(3'd1, 32'd9, 32'd0, 4'd11, 1'b0, lat, leak);
    checkOutput("div0Tag", {28'd0, out_tag}, 32'd11);
`ifdef MUL_DIV_SEQ_DIV_ZERO_BYPASS_EN
    checkOutput("div0Latency", lat, 32'd2);
    checkOutput("div0Result", out_result, 32'hFFFF_FFFF);
    checkOutput("div0NoEnable", divEnCount - divBase, 32'd0);
`else
    checkOutput("div0LatencyOk", {31'd0, lat <= 40}, 32'd1);
    checkOutput("div0Dispatched", divEnCount - divBase, 32'd1);
`endif

    @(negedge clk);
    checkOutput("neverBothEnabled", bothEnCount, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
